// File: rtl/strap_seq_ctrl.sv
// Strap sampling and reset-sequence controller: majority-votes the pad straps after
// e_reset_n release, then sequences p_reset_n, clk_enb and s_reset_n, with sticky words and soft reboot.
module strap_seq_ctrl #(
    parameter int         PSTRAP_W       = 8,
    parameter int         NUM_STICKY     = 2,
    parameter int         SAMPLE_CNT     = 3,
    parameter int         CLK_ENB_DLY    = 16,
    parameter int         SRST_DLY       = 16,
    parameter logic [7:0] PSTRAP_DEFAULT = 8'h74,
    localparam int        AW             = (NUM_STICKY > 1) ? $clog2(NUM_STICKY) : 1
) (
    input  logic                    clk,
    input  logic                    e_reset_n,
    input  logic [PSTRAP_W-1:0]     pad_strap_in,
    input  logic                    cs,
    input  logic [AW-1:0]           addr,
    input  logic [3:0]              we,
    input  logic [31:0]             data_in,
    output logic [31:0]             rdata,
    output logic [PSTRAP_W-1:0]     strap_latch,
    output logic [32*NUM_STICKY-1:0] strap_sticky,
    output logic                    p_reset_n,
    output logic                    clk_enb,
    output logic                    s_reset_n,
    output logic                    seq_busy
);

    localparam int MAX_DLY = (CLK_ENB_DLY > SRST_DLY)
                           ? ((CLK_ENB_DLY > SAMPLE_CNT) ? CLK_ENB_DLY : SAMPLE_CNT)
                           : ((SRST_DLY > SAMPLE_CNT) ? SRST_DLY : SAMPLE_CNT);
    localparam int CW = $clog2(MAX_DLY + 1);
    localparam int VW = $clog2(SAMPLE_CNT + 1);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, LOAD, CLK_WAIT, RST_WAIT, RUN, REBOOT
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [VW-1:0]         ones_reg [PSTRAP_W];
    logic [VW-1:0]         ones_next [PSTRAP_W];
    logic [PSTRAP_W-1:0]   latch_reg, latch_next;
    logic [31:0]           sticky_reg [NUM_STICKY];
    logic [31:0]           sticky_next [NUM_STICKY];
    logic                  p_rst_reg, p_rst_next;
    logic                  clk_enb_reg, clk_enb_next;
    logic                  s_rst_reg, s_rst_next;
    logic                  addr_ok;
    logic [VW-1:0]         vote_sum;

    // Default mode swaps the low strap byte for PSTRAP_DEFAULT; pad bits above 7 pass straight through.
    function automatic logic [31:0] strap_map(input logic [PSTRAP_W-1:0] l);
        logic [7:0]  sel;
        logic [21:0] lx;
        logic [31:0] w;
        sel      = l[7] ? PSTRAP_DEFAULT : l[7:0];
        lx       = 22'(l);
        w        = 32'h0000_4000;
        w[29:16] = lx[21:8];
        w[13]    = sel[6];
        w[12]    = sel[5];
        w[11:10] = sel[4:3];
        w[9]     = sel[2];
        w[8]     = sel[1];
        w[4]     = sel[0];
        w[0]     = sel[0];
        return w;
    endfunction

    assign addr_ok = (int'(addr) < NUM_STICKY);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        ones_next    = ones_reg;
        latch_next   = latch_reg;
        sticky_next  = sticky_reg;
        p_rst_next   = p_rst_reg;
        clk_enb_next = clk_enb_reg;
        s_rst_next   = s_rst_reg;
        vote_sum     = '0;
        case (state_reg)
            IDLE: begin
                for (int b = 0; b < PSTRAP_W; b++) ones_next[b] = '0;
                cnt_next   = '0;
                state_next = SAMPLE;
            end
            SAMPLE: begin
                for (int b = 0; b < PSTRAP_W; b++) begin
                    vote_sum = ones_reg[b] + VW'(pad_strap_in[b]);
                    if (cnt_reg == CW'(SAMPLE_CNT - 1)) begin
                        latch_next[b] = (vote_sum > VW'(SAMPLE_CNT / 2));
                        ones_next[b]  = '0;
                    end else begin
                        ones_next[b]  = vote_sum;
                    end
                end
                if (cnt_reg == CW'(SAMPLE_CNT - 1)) begin
                    cnt_next   = '0;
                    state_next = LOAD;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LOAD: begin
                sticky_next[0] = strap_map(latch_reg);
                for (int n = 1; n < NUM_STICKY; n++) sticky_next[n] = '0;
                p_rst_next = 1'b1;
                cnt_next   = '0;
                state_next = CLK_WAIT;
            end
            CLK_WAIT: begin
                if (cnt_reg == CW'(CLK_ENB_DLY - 1)) begin
                    clk_enb_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = RST_WAIT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RST_WAIT: begin
                if (cnt_reg == CW'(SRST_DLY - 1)) begin
                    s_rst_next = 1'b1;
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                if (sticky_reg[0][31]) state_next = REBOOT;
                if (cs && addr_ok) begin
                    for (int k = 0; k < 4; k++) begin
                        if (we[k]) sticky_next[addr][8*k +: 8] = data_in[8*k +: 8];
                    end
                end
            end
            REBOOT: begin
                s_rst_next        = 1'b0;
                clk_enb_next      = 1'b0;
                sticky_next[0][31] = 1'b0;
                cnt_next          = '0;
                state_next        = CLK_WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge e_reset_n) begin
        if (!e_reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            latch_reg   <= '0;
            p_rst_reg   <= 1'b0;
            clk_enb_reg <= 1'b0;
            s_rst_reg   <= 1'b0;
            for (int b = 0; b < PSTRAP_W; b++) ones_reg[b] <= '0;
            for (int n = 0; n < NUM_STICKY; n++) sticky_reg[n] <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            latch_reg   <= latch_next;
            p_rst_reg   <= p_rst_next;
            clk_enb_reg <= clk_enb_next;
            s_rst_reg   <= s_rst_next;
            for (int b = 0; b < PSTRAP_W; b++) ones_reg[b] <= ones_next[b];
            for (int n = 0; n < NUM_STICKY; n++) sticky_reg[n] <= sticky_next[n];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STICKY; gi++) begin : g_pack
            assign strap_sticky[32*gi +: 32] = sticky_reg[gi];
        end
    endgenerate

    assign rdata       = addr_ok ? sticky_reg[addr] : 32'h0;
    assign strap_latch = latch_reg;
    assign p_reset_n   = p_rst_reg;
    assign clk_enb     = clk_enb_reg;
    assign s_reset_n   = s_rst_reg;
    assign seq_busy    = (state_reg != RUN);

endmodule
